// File: rtl/address_multiply_issue.sv
// Issue/write-back sequencer for the 32-bit address multiply pipeline (022/023).
// Optional write-back forwarding is enabled by defining ADDR_MUL_BYPASS_EN.
module address_multiply_issue #(
  parameter int WIDTH       = 32,
  parameter int AREGS       = 8,
  parameter int IDX_W       = 3,
  parameter int MUL_LATENCY = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_issue_valid,
  output logic             o_issue_ready,
  input  logic [IDX_W-1:0] i_dst,
  input  logic [IDX_W-1:0] i_srcj,
  input  logic [IDX_W-1:0] i_srck,
  output logic [IDX_W-1:0] o_rd_j_idx,
  output logic [IDX_W-1:0] o_rd_k_idx,
  input  logic [WIDTH-1:0] i_rd_j_data,
  input  logic [WIDTH-1:0] i_rd_k_data,
  output logic [WIDTH-1:0] o_mul_Aj,
  output logic [WIDTH-1:0] o_mul_Ak,
  input  logic [WIDTH-1:0] i_mul_Ai,
  output logic             o_wr_en,
  output logic [IDX_W-1:0] o_wr_idx,
  output logic [WIDTH-1:0] o_wr_data,
  output logic [AREGS-1:0] o_busy,
  output logic [3:0]       o_inflight
);

  logic [WIDTH-1:0]       mul_aj_q, mul_aj_d;
  logic [WIDTH-1:0]       mul_ak_q, mul_ak_d;
  logic [MUL_LATENCY-1:0] tag_valid_q, tag_valid_d;
  logic [IDX_W-1:0]       tag_idx_q [MUL_LATENCY];
  logic [IDX_W-1:0]       tag_idx_d [MUL_LATENCY];
  logic                   wr_en_q, wr_en_d;
  logic [IDX_W-1:0]       wr_idx_q, wr_idx_d;
  logic [AREGS-1:0]       busy_q, busy_d;
  logic [3:0]             inflight_q, inflight_d;

  logic [AREGS-1:0] wr_mask;
  logic [AREGS-1:0] busy_eff;
  logic             fwd_j, fwd_k;
  logic             issue_ready;
  logic             accept;

  // Hazard check: reservations, optionally relaxed for the register being written back now.
  always_comb begin
    wr_mask = wr_en_q ? ({{(AREGS-1){1'b0}}, 1'b1} << wr_idx_q) : {AREGS{1'b0}};
`ifdef ADDR_MUL_BYPASS_EN
    busy_eff = busy_q & ~wr_mask;
    fwd_j    = wr_en_q && (i_srcj == wr_idx_q);
    fwd_k    = wr_en_q && (i_srck == wr_idx_q);
`else
    busy_eff = busy_q;
    fwd_j    = 1'b0;
    fwd_k    = 1'b0;
`endif
    issue_ready = !busy_eff[i_dst] && !busy_eff[i_srcj] && !busy_eff[i_srck];
    accept      = i_issue_valid && issue_ready;
  end

  // Next-state: operand capture, tag pipeline, reservations and in-flight count.
  always_comb begin
    mul_aj_d    = mul_aj_q;
    mul_ak_d    = mul_ak_q;
    busy_d      = busy_q;
    inflight_d  = inflight_q;
    if (accept) begin
      mul_aj_d = fwd_j ? i_mul_Ai : i_rd_j_data;
      mul_ak_d = fwd_k ? i_mul_Ai : i_rd_k_data;
    end else begin
      mul_aj_d = mul_aj_q;
      mul_ak_d = mul_ak_q;
    end

    tag_valid_d  = {tag_valid_q[MUL_LATENCY-2:0], accept};
    tag_idx_d[0] = accept ? i_dst : {IDX_W{1'b0}};
    for (int s = 1; s < MUL_LATENCY; s++) begin
      tag_idx_d[s] = tag_idx_q[s-1];
    end
    wr_en_d  = tag_valid_q[MUL_LATENCY-1];
    wr_idx_d = tag_idx_q[MUL_LATENCY-1];

    // Clear first so a same-edge re-reservation of the written register wins.
    busy_d = busy_q & ~wr_mask;
    if (accept) begin
      busy_d[i_dst] = 1'b1;
    end else begin
      busy_d = busy_q & ~wr_mask;
    end

    case ({accept, wr_en_q})
      2'b10:   inflight_d = inflight_q + 4'd1;
      2'b01:   inflight_d = inflight_q - 4'd1;
      default: inflight_d = inflight_q;
    endcase
  end

  // State registers with synchronous reset discarding every in-flight tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_aj_q    <= {WIDTH{1'b0}};
      mul_ak_q    <= {WIDTH{1'b0}};
      tag_valid_q <= {MUL_LATENCY{1'b0}};
      for (int s = 0; s < MUL_LATENCY; s++) begin
        tag_idx_q[s] <= {IDX_W{1'b0}};
      end
      wr_en_q     <= 1'b0;
      wr_idx_q    <= {IDX_W{1'b0}};
      busy_q      <= {AREGS{1'b0}};
      inflight_q  <= 4'd0;
    end else begin
      mul_aj_q    <= mul_aj_d;
      mul_ak_q    <= mul_ak_d;
      tag_valid_q <= tag_valid_d;
      for (int s = 0; s < MUL_LATENCY; s++) begin
        tag_idx_q[s] <= tag_idx_d[s];
      end
      wr_en_q     <= wr_en_d;
      wr_idx_q    <= wr_idx_d;
      busy_q      <= busy_d;
      inflight_q  <= inflight_d;
    end
  end

  assign o_issue_ready = issue_ready;
  assign o_rd_j_idx    = i_srcj;
  assign o_rd_k_idx    = i_srck;
  assign o_mul_Aj      = mul_aj_q;
  assign o_mul_Ak      = mul_ak_q;
  assign o_wr_en       = wr_en_q;
  assign o_wr_idx      = wr_idx_q;
  assign o_wr_data     = i_mul_Ai;
  assign o_busy        = busy_q;
  assign o_inflight    = inflight_q;

endmodule

// File: tb/tb_address_multiply_issue.sv
// Directed bench for address_multiply_issue; a 7-stage multiplier model feeds i_mul_Ai.
// Expectations switch on ADDR_MUL_BYPASS_EN where forwarding changes timing.
module tb_address_multiply_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_issue_valid;
  logic        o_issue_ready;
  logic [2:0]  i_dst, i_srcj, i_srck;
  logic [2:0]  o_rd_j_idx, o_rd_k_idx;
  logic [31:0] i_rd_j_data, i_rd_k_data;
  logic [31:0] o_mul_Aj, o_mul_Ak;
  logic [31:0] i_mul_Ai;
  logic        o_wr_en;
  logic [2:0]  o_wr_idx;
  logic [31:0] o_wr_data;
  logic [7:0]  o_busy;
  logic [3:0]  o_inflight;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mpipe [7];

  address_multiply_issue dut (
    .clk(clk), .rst(rst),
    .i_issue_valid(i_issue_valid), .o_issue_ready(o_issue_ready),
    .i_dst(i_dst), .i_srcj(i_srcj), .i_srck(i_srck),
    .o_rd_j_idx(o_rd_j_idx), .o_rd_k_idx(o_rd_k_idx),
    .i_rd_j_data(i_rd_j_data), .i_rd_k_data(i_rd_k_data),
    .o_mul_Aj(o_mul_Aj), .o_mul_Ak(o_mul_Ak), .i_mul_Ai(i_mul_Ai),
    .o_wr_en(o_wr_en), .o_wr_idx(o_wr_idx), .o_wr_data(o_wr_data),
    .o_busy(o_busy), .o_inflight(o_inflight)
  );

  always #5 clk = ~clk;

  // Multiplier model: product of the registered operands appears 7 cycles later.
  always @(posedge clk) begin
    mpipe[0] <= o_mul_Aj * o_mul_Ak;
    for (int s = 1; s < 7; s++) mpipe[s] <= mpipe[s-1];
  end
  assign i_mul_Ai = mpipe[6];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] d, input logic [2:0] j, input logic [2:0] k,
                       input logic [31:0] dj, input logic [31:0] dk);
    i_issue_valid = 1'b1;
    i_dst = d; i_srcj = j; i_srck = k;
    i_rd_j_data = dj; i_rd_k_data = dk;
  endtask

  initial begin
    rst = 1'b1; i_issue_valid = 1'b0;
    i_dst = 3'd0; i_srcj = 3'd0; i_srck = 3'd0;
    i_rd_j_data = 32'd0; i_rd_k_data = 32'd0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; #1;
    chk("rst_busy", o_busy, 32'h0);
    chk("rst_inflight", o_inflight, 32'd0);
    chk("rst_wr_en", o_wr_en, 32'd0);
    chk("rst_wr_idx", o_wr_idx, 32'd0);
    chk("rst_Aj", o_mul_Aj, 32'd0);
    chk("rst_Ak", o_mul_Ak, 32'd0);
    chk("rst_ready", o_issue_ready, 32'd1);

    // Single op: A3 = A1*A2 = 6*7
    issue(3'd3, 3'd1, 3'd2, 32'd6, 32'd7); #1;
    chk("single_ready", o_issue_ready, 32'd1);
    chk("rd_j_idx", o_rd_j_idx, 32'd1);
    chk("rd_k_idx", o_rd_k_idx, 32'd2);
    nxt(); i_issue_valid = 1'b0; #1;
    chk("single_Aj", o_mul_Aj, 32'd6);
    chk("single_Ak", o_mul_Ak, 32'd7);
    chk("single_inflight", o_inflight, 32'd1);
    chk("single_busy_c1", o_busy, 32'h08);
    for (int c = 2; c <= 8; c++) begin
      nxt(); #1;
      chk("single_busy", o_busy, 32'h08);
      if (c < 8) chk("single_no_wr", o_wr_en, 32'd0);
    end
    chk("single_wr_en", o_wr_en, 32'd1);
    chk("single_wr_idx", o_wr_idx, 32'd3);
    chk("single_wr_data", o_wr_data, 32'd42);
    nxt(); #1;
    chk("single_busy_c9", o_busy, 32'h00);
    chk("single_wr_off", o_wr_en, 32'd0);
    chk("single_inflight0", o_inflight, 32'd0);

    // Back-to-back: cycle c issues Ac = (c+1)*(c+2)
    nxt();
    for (int c = 0; c < 8; c++) begin
      issue(3'(c), 3'(c), 3'(c), 32'(c + 1), 32'(c + 2)); #1;
      chk("b2b_ready", o_issue_ready, 32'd1);
      nxt();
    end
    i_issue_valid = 1'b0; #1;
    chk("b2b_inflight8", o_inflight, 32'd8);
    chk("b2b_busy_all", o_busy, 32'hFF);
    for (int n = 0; n < 8; n++) begin
      if (n > 0) begin nxt(); #1; end
      chk("b2b_wr_en", o_wr_en, 32'd1);
      chk("b2b_wr_idx", o_wr_idx, 32'(n));
      chk("b2b_wr_data", o_wr_data, 32'((n + 1) * (n + 2)));
    end
    nxt(); #1;
    chk("b2b_inflight0", o_inflight, 32'd0);
    chk("b2b_busy0", o_busy, 32'h00);

    // RAW: A4 = A1*A2, then A5 = A4*A1
    nxt();
    issue(3'd4, 3'd1, 3'd2, 32'd6, 32'd7); #1;
    chk("raw_first_ready", o_issue_ready, 32'd1);
    nxt();
    issue(3'd5, 3'd4, 3'd1, 32'h0000_0BAD, 32'd6); #1;
    chk("raw_stall", o_issue_ready, 32'd0);
    for (int c = 2; c <= 7; c++) begin
      nxt(); #1;
      chk("raw_stall", o_issue_ready, 32'd0);
    end
    nxt(); #1;
`ifdef ADDR_MUL_BYPASS_EN
    chk("raw_bypass_ready_c8", o_issue_ready, 32'd1);
    nxt(); i_issue_valid = 1'b0; #1;
`else
    chk("raw_stall_c8", o_issue_ready, 32'd0);
    nxt(); i_rd_j_data = 32'd42; #1;
    chk("raw_ready_c9", o_issue_ready, 32'd1);
    nxt(); i_issue_valid = 1'b0; #1;
`endif
    chk("raw_Aj", o_mul_Aj, 32'd42);
    chk("raw_Ak", o_mul_Ak, 32'd6);
    repeat (9) nxt();
    #1;
    chk("raw_drain_busy", o_busy, 32'h00);
    chk("raw_drain_inflight", o_inflight, 32'd0);

    // WAW: second write to A3 while A3 reserved
    nxt();
    issue(3'd3, 3'd1, 3'd2, 32'd6, 32'd7); #1;
    nxt();
    issue(3'd3, 3'd0, 3'd0, 32'd5, 32'd5); #1;
    chk("waw_stall", o_issue_ready, 32'd0);
    for (int c = 2; c <= 7; c++) begin
      nxt(); #1;
      chk("waw_stall", o_issue_ready, 32'd0);
    end
    nxt(); #1;
`ifdef ADDR_MUL_BYPASS_EN
    chk("waw_bypass_ready_c8", o_issue_ready, 32'd1);
`else
    chk("waw_stall_c8", o_issue_ready, 32'd0);
    nxt(); #1;
    chk("waw_ready_c9", o_issue_ready, 32'd1);
`endif
    nxt(); i_issue_valid = 1'b0; #1;
    chk("waw_busy_kept", o_busy, 32'h08);
    chk("waw_inflight", o_inflight, 32'd1);
    repeat (7) nxt();
    #1;
    chk("waw_wr_en", o_wr_en, 32'd1);
    chk("waw_wr_idx", o_wr_idx, 32'd3);
    chk("waw_wr_data", o_wr_data, 32'd25);
    nxt(); #1;
    chk("waw_busy0", o_busy, 32'h00);

    // Truncation: 0xFFFFFFFF * 2
    nxt();
    issue(3'd6, 3'd0, 3'd1, 32'hFFFF_FFFF, 32'd2); #1;
    nxt(); i_issue_valid = 1'b0;
    repeat (7) nxt();
    #1;
    chk("trunc_wr_en", o_wr_en, 32'd1);
    chk("trunc_wr_idx", o_wr_idx, 32'd6);
    chk("trunc_wr_data", o_wr_data, 32'hFFFF_FFFE);
    nxt(); #1;

    // Reset with three ops in flight (plus a colliding issue that reset overrides)
    nxt();
    issue(3'd0, 3'd0, 3'd0, 32'd2, 32'd3);
    nxt();
    issue(3'd1, 3'd1, 3'd1, 32'd2, 32'd3);
    nxt();
    issue(3'd2, 3'd2, 3'd2, 32'd2, 32'd3);
    nxt();
    i_issue_valid = 1'b0; #1;
    chk("pre_rst_inflight", o_inflight, 32'd3);
    chk("pre_rst_busy", o_busy, 32'h07);
    nxt();
    rst = 1'b1;
    issue(3'd5, 3'd5, 3'd5, 32'd9, 32'd9);
    nxt();
    rst = 1'b0;
    issue(3'd7, 3'd7, 3'd7, 32'd3, 32'd4); #1;
    chk("post_rst_busy", o_busy, 32'h00);
    chk("post_rst_inflight", o_inflight, 32'd0);
    chk("post_rst_wr_en", o_wr_en, 32'd0);
    chk("post_rst_ready", o_issue_ready, 32'd1);
    nxt(); i_issue_valid = 1'b0; #1;
    chk("post_rst_accept_busy", o_busy, 32'h80);
    chk("post_rst_accept_inflight", o_inflight, 32'd1);
    chk("post_rst_Aj", o_mul_Aj, 32'd3);
    chk("post_rst_no_wr_c6", o_wr_en, 32'd0);
    for (int c = 7; c <= 12; c++) begin
      nxt(); #1;
      chk("post_rst_no_wr", o_wr_en, 32'd0);
    end
    nxt(); #1;
    chk("post_rst_wr_en", o_wr_en, 32'd1);
    chk("post_rst_wr_idx", o_wr_idx, 32'd7);
    chk("post_rst_wr_data", o_wr_data, 32'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/address_multiply_issue.md
# address_multiply_issue

Issue and write-back sequencer for the address multiply path (instructions 022/023). It sits directly upstream and downstream of the 32-bit address multiply pipeline. It accepts multiply issues, reads Aj/Ak from the A register file and presents the operands to the multiplier. It tracks each destination index through the fixed multiply latency, writes the product into Ai, and maintains per-register reservations so dependent instructions stall until their operands are valid.

## Interface
- WIDTH, 32: operand/result width.
- AREGS, 8: number of A registers.
- IDX_W, 3: register index width, log2(AREGS).
- MUL_LATENCY, 7: cycles from operands on o_mul_Aj/o_mul_Ak to product on i_mul_Ai.

Ports. One clock; reset is synchronous and active-high.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- i_issue_valid  in  1  multiply instruction presented.
- o_issue_ready  out  1  issue may be accepted this cycle.
- i_dst  in  IDX_W  destination index i.
- i_srcj, i_srck  in  IDX_W  source indices j, k.
- o_rd_j_idx, o_rd_k_idx  out  IDX_W  A-file read addresses, equal to i_srcj/i_srck (combinational).
- i_rd_j_data, i_rd_k_data  in  WIDTH  A-file combinational read data.
- o_mul_Aj, o_mul_Ak  out  WIDTH  registered multiplier operands.
- i_mul_Ai  in  WIDTH  multiplier product, low WIDTH bits.
- o_wr_en  out  1  A-file write strobe.
- o_wr_idx  out  IDX_W  A-file write index.
- o_wr_data  out  WIDTH  equals i_mul_Ai.
- o_busy  out  AREGS  reservation vector; bit n set means An is pending.
- o_inflight  out  4  count of outstanding multiplies.

## Operation
- Accept means i_issue_valid && o_issue_ready, sampled at the rising edge.
- o_issue_ready = !busy[i_dst] && !busy[i_srcj] && !busy[i_srck]. It is combinational from registered state. It covers RAW on j/k and WAW on i.
- On accept:
  - o_mul_Aj/o_mul_Ak load the (possibly forwarded) read data.
  - busy[i_dst] sets.
  - Tag {valid=1, idx=i_dst} enters stage 0 of a MUL_LATENCY-deep tag shift register.
- Without accept, o_mul_* hold their value and a valid=0 bubble enters stage 0.
- Tags shift every cycle with no stall.
- Final tag stage drives write-back:
  - o_wr_en = tag valid; o_wr_idx = tag idx; o_wr_data = i_mul_Ai.
  - On that edge busy[o_wr_idx] clears, unless the same edge sets it again through a new accept to the same index, in which case set wins.
- o_inflight increments on accept, decrements on o_wr_en; both in the same cycle leaves it unchanged. Maximum is MUL_LATENCY+1.
- Product is truncated to WIDTH bits. No overflow flag.
- dst equal to srcj/srck in one instruction is legal; sources are read before the reservation is set.

## Timing
- Issue accepted in cycle T:
  - o_mul_* valid in T+1.
  - i_mul_Ai and o_wr_en valid in T+1+MUL_LATENCY (T+8 at default).
  - busy clears at the end of T+8.
- Dependent issue earliest acceptance: T+9 without bypass, T+8 with bypass.
- Throughput is one issue per cycle when there are no hazards.
- Reset values:
  - o_mul_Aj/o_mul_Ak = 0.
  - o_busy = 0.
  - All tags invalid, so o_wr_en = 0 and o_wr_idx = 0.
  - o_inflight = 0.
  - o_issue_ready = 1.
- Reset mid-operation discards all in-flight tags. No write-back occurs for them. Multiplier output produced after reset is ignored.
- rst has priority over accept in the same cycle.

## Configuration
- ADDR_MUL_BYPASS_EN defined:
  - A source whose index equals o_wr_idx while o_wr_en is high counts as not busy for o_issue_ready.
  - Its operand is taken from i_mul_Ai instead of i_rd_*_data.
  - dst hazard is unchanged: a reserved i_dst still stalls, except when i_dst equals o_wr_idx with o_wr_en high, where the issue is accepted and busy stays set.
- ADDR_MUL_BYPASS_EN undefined: any set busy bit stalls; no forwarding.

## Test plan
- Single op, A1=6, A2=7, issue i=3 in cycle 0 -> o_mul_Aj=6, o_mul_Ak=7 in cycle 1; o_wr_en=1, idx=3, data=42 in cycle 8; o_busy[3] set cycles 1-8, clear in cycle 9.
- Back-to-back independent issues in cycles 0-7 to A0..A7 -> o_inflight reaches 8; write-backs in cycles 8-15 in order; o_issue_ready stays 1.
- RAW: issue A4=A1*A2 in cycle 0, then A5=A4*A1 presented from cycle 1 -> ready=0 until cycle 9 (no bypass) or cycle 8 with operand equal to i_mul_Ai (bypass).
- WAW: second issue to i=3 while busy[3] -> stalled until write-back; only then accepted.
- Truncation: 0xFFFFFFFF*0x00000002 -> o_wr_data=0xFFFFFFFE.
- Reset in cycle 4 with 3 ops in flight -> o_busy=0, o_inflight=0, no o_wr_en for those ops; issue in cycle 5 is accepted.
